mem_writeback_stage: RTL and testbench
======================================

// Module: mem_writeback_stage
// PURPOSE
//  Back end of the CPU pipeline: takes the registered EX outputs (ALU result, stored Rt, dest reg, control)
//  and performs the data-memory access over a req/ack handshake.
//  Then drives the register-file write port (WriteData / WriteRegister / RegWrite) that the decode stage
//  consumes; the register file samples these on the falling clock edge.
//  Stalls upstream via in_ready while a memory access is outstanding.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles mem_req may wait for mem_ack before the access is aborted (>=1)
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  reset          in   1   asynchronous, active-low reset
//  in_valid       in   1   EX-stage result valid this cycle
//  in_ready       out  1   stage can accept an op this cycle
//  alu_result     in   32  ALU output; memory address for loads/stores
//  store_data     in   32  Rt value to be stored
//  dest_reg       in   5   destination register address (already Rt/Rd muxed)
//  reg_write      in   1   op writes the register file
//  mem_read       in   1   op is a load
//  mem_write      in   1   op is a store
//  mem_req        out  1   data-memory request
//  mem_we         out  1   1 = write, 0 = read
//  mem_addr       out  32  request address
//  mem_wdata      out  32  store data
//  mem_ack        in   1   memory completes request this cycle
//  mem_rdata      in   32  load data, valid when mem_ack=1
//  WriteData      out  32  register-file write data
//  WriteRegister  out  5   register-file write address
//  RegWrite       out  1   register-file write enable
//  mem_err        out  1   one-cycle pulse: access timed out
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; all outputs 0 except in_ready=1; timeout counter 0; op regs cleared.
//  - FSM states:
//    - IDLE: in_ready=1, RegWrite=0.
//    - ACCESS: in_ready=0, mem_req=1.
//    - WB: in_ready=1, RegWrite=captured reg_write & (dest!=0).
//  - Accept: in_valid & in_ready at a rising edge captures all inputs.
//    - Next state is ACCESS if mem_read|mem_write.
//    - Otherwise WB if reg_write.
//    - Otherwise IDLE.
//  - Simultaneous mem_read & mem_write: treated as load (mem_we=0).
//  - ACCESS:
//    - mem_addr, mem_we and mem_wdata are driven from captured regs and held stable until ack.
//    - Counter increments every cycle without ack.
//    - mem_ack=1 on a load: mem_rdata captured into WriteData; go to WB.
//    - mem_ack=1 on a store: go to IDLE, no register write.
//    - Counter == MEM_TIMEOUT-1 and no ack: mem_req drops, mem_err=1 next cycle for one cycle, go to IDLE,
//      no register write. Counter clears on leaving ACCESS.
//  - WB:
//    - Exactly one cycle.
//    - WriteData = alu_result (ALU op) or load data; WriteRegister = dest_reg.
//    - A new op may be accepted in the same cycle (back-to-back ALU ops: one RegWrite per cycle).
//  - Latency:
//    - ALU op accepted at edge N: RegWrite high during cycle N+1.
//    - Load accepted at edge N: mem_req high from cycle N+1; ack sampled at edge M: RegWrite high in cycle M+1.
//  - dest_reg=0: RegWrite forced 0; WriteData/WriteRegister still updated.
//  - mem_ack outside ACCESS is ignored. in_valid while in_ready=0 is ignored; upstream must hold its values.
//  - Reset mid-access: mem_req drops immediately; the pending op is discarded, no write-back.
//  - WriteData/WriteRegister hold their last values outside WB; only RegWrite qualifies them.
// TESTING
//  1. ALU ops back-to-back:
//     - Stimulus: in_valid on 3 consecutive cycles, alu_result=5/6/7, dest=1/2/3.
//     - Expect: RegWrite on 3 consecutive cycles, writes R1=5, R2=6, R3=7; in_ready stays 1.
//  2. Load, ack after 3 cycles:
//     - Stimulus: addr=0x40, mem_rdata=0xDEADBEEF, dest=8.
//     - Expect: mem_req high 3 cycles with mem_we=0 and addr stable; in_ready=0 throughout;
//       next cycle RegWrite=1 writing R8=0xDEADBEEF.
//  3. Store, immediate ack:
//     - Stimulus: addr=0x10, store_data=0x1234.
//     - Expect: one mem_req cycle with mem_we=1 and wdata=0x1234; RegWrite never asserted.
//  4. Timeout:
//     - Stimulus: load, mem_ack held 0.
//     - Expect: mem_req high exactly 15 cycles, then mem_err pulses 1 cycle, no RegWrite,
//       in_ready returns to 1.
//  5. Write to R0:
//     - Stimulus: ALU op with dest=0, alu_result=9.
//     - Expect: RegWrite stays 0.
//  6. Reset mid-access:
//     - Stimulus: reset low during ACCESS.
//     - Expect: mem_req=0 without waiting for clk; after release the stage is in IDLE, in_ready=1,
//       and no write of the discarded op occurs.

Source files
------------

// File: rtl/mem_writeback_stage.sv
// MEM/WB back end: data-memory access over req/ack and register-file write-back.
// Holds off upstream (in_ready=0) while a memory access is outstanding.
module mem_writeback_stage #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteRegister,
  output logic        RegWrite,
  output logic        mem_err
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WB
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [RW-1:0] dest_q, dest_d;
  logic          regw_q, regw_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [RW-1:0] wb_reg_q, wb_reg_d;
  logic          reg_write_out_q, reg_write_out_d;
  logic          in_ready_q, in_ready_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_err_q, mem_err_d;

  // Next-state, capture and write-back logic
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    we_d            = we_q;
    dest_d          = dest_q;
    regw_d          = regw_q;
    wb_data_d       = wb_data_q;
    wb_reg_d        = wb_reg_q;
    reg_write_out_d = 1'b0;
    mem_err_d       = 1'b0;

    unique case (state_q)
      S_IDLE, S_WB: begin
        state_d = S_IDLE;
        if (in_valid) begin
          addr_d  = alu_result;
          wdata_d = store_data;
          we_d    = mem_write & ~mem_read;
          dest_d  = dest_reg;
          regw_d  = reg_write;
          if (mem_read | mem_write) begin
            state_d = S_ACCESS;
            cnt_d   = '0;
          end else if (reg_write) begin
            state_d         = S_WB;
            wb_data_d       = alu_result;
            wb_reg_d        = dest_reg;
            reg_write_out_d = (dest_reg != '0);
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          cnt_d = '0;
          if (we_q) begin
            state_d = S_IDLE;
          end else begin
            state_d         = S_WB;
            wb_data_d       = mem_rdata;
            wb_reg_d        = dest_q;
            reg_write_out_d = regw_q & (dest_q != '0);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    in_ready_d = (state_d != S_ACCESS);
    mem_req_d  = (state_d == S_ACCESS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      we_q            <= 1'b0;
      dest_q          <= '0;
      regw_q          <= 1'b0;
      wb_data_q       <= '0;
      wb_reg_q        <= '0;
      reg_write_out_q <= 1'b0;
      in_ready_q      <= 1'b1;
      mem_req_q       <= 1'b0;
      mem_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      we_q            <= we_d;
      dest_q          <= dest_d;
      regw_q          <= regw_d;
      wb_data_q       <= wb_data_d;
      wb_reg_q        <= wb_reg_d;
      reg_write_out_q <= reg_write_out_d;
      in_ready_q      <= in_ready_d;
      mem_req_q       <= mem_req_d;
      mem_err_q       <= mem_err_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign WriteData     = wb_data_q;
  assign WriteRegister = wb_reg_q;
  assign RegWrite      = reg_write_out_q;
  assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Bench for mem_writeback_stage: expected register writes are queued at drive time
// and compared against writes the monitor observes on the register-file port.
module tb_mem_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] WriteData;
  logic [4:0]  WriteRegister;
  logic        RegWrite;
  logic        mem_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] c;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];

  mem_writeback_stage #(.MEM_TIMEOUT(15)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .dest_reg     (dest_reg),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .WriteData    (WriteData),
    .WriteRegister(WriteRegister),
    .RegWrite     (RegWrite),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file side: record every qualified write, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n && RegWrite)
      obs_q.push_back('{r: WriteRegister, d: WriteData, c: 32'(cyc)});
  end

  task automatic drive_idle();
    in_valid   = 1'b0;
    alu_result = $urandom;
    store_data = $urandom;
    dest_reg   = '0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] s, input logic [4:0] d,
                          input logic rw, input logic mr, input logic mw);
    in_valid   = 1'b1;
    alu_result = a;
    store_data = s;
    dest_reg   = d;
    reg_write  = rw;
    mem_read   = mr;
    mem_write  = mw;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    drive_idle();
    #12;
    total++;
    if ({in_ready, mem_req, RegWrite, mem_err, mem_we} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy/req/rw/err/we=%b want 10000",
               {in_ready, mem_req, RegWrite, mem_err, mem_we});
    end
    total++;
    if ({WriteData, WriteRegister, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_data: got wd=%h wr=%0d addr=%h wdata=%h want all 0",
               WriteData, WriteRegister, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_back_to_back();
    wr_t e, o;
    int  first_c;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive_op(32'(5 + i), $urandom, 5'(1 + i), 1'b1, 1'b0, 1'b0);
      exp_q.push_back('{r: 5'(1 + i), d: 32'(5 + i), c: 32'd0});
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL alu_in_ready[%0d]: got %b want 1", i, in_ready);
      end
    end
    @(posedge clk); #1;
    drive_idle();
    repeat (3) @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL alu_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    first_c = (obs_q.size() > 0) ? int'(obs_q[0].c) : 0;
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o.r !== e.r || o.d !== e.d || int'(o.c) != first_c + i) begin
        bad++;
        $display("FAIL alu_write[%0d]: got R%0d=%0d at +%0d want R%0d=%0d at +%0d",
                 i, o.r, o.d, int'(o.c) - first_c, e.r, e.d, i);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_load();
    wr_t e, o;
    @(posedge clk); #1;
    drive_op(32'h40, $urandom, 5'd8, 1'b1, 1'b1, 1'b0);
    exp_q.push_back('{r: 5'd8, d: 32'hDEADBEEF, c: 32'd0});
    @(posedge clk); #1;
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
      end
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL load_access[%0d]: got req=%b we=%b addr=%h rdy=%b want 1 0 00000040 0",
                 k, mem_req, mem_we, mem_addr, in_ready);
      end
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
    @(negedge clk);
    total++;
    if (RegWrite !== 1'b1 || mem_req !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_wb: got rw=%b req=%b rdy=%b want 1 0 1", RegWrite, mem_req, in_ready);
    end
    repeat (2) @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL load_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o.r !== e.r || o.d !== e.d) begin
        bad++;
        $display("FAIL load_write: got R%0d=%h want R%0d=%h", o.r, o.d, e.r, e.d);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_store();
    int req_cycles = 0;
    @(posedge clk); #1;
    drive_op(32'h10, 32'h1234, 5'd5, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive_idle();
    mem_ack = 1'b1;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1234 || mem_addr !== 32'h10) begin
      bad++;
      $display("FAIL store_access: got req=%b we=%b wdata=%h addr=%h want 1 1 00001234 00000010",
               mem_req, mem_we, mem_wdata, mem_addr);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
    end
    total++;
    if (req_cycles != 0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL store_after: got extra_req=%0d writes=%0d want 0 0", req_cycles, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int err_cycles = 0;
    int last_req   = -1;
    int err_at     = -1;
    @(posedge clk); #1;
    drive_op(32'h80, $urandom, 5'd4, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        last_req = k;
      end
      if (mem_err) begin
        err_cycles++;
        err_at = k;
      end
    end
    total++;
    if (req_cycles != 15) begin
      bad++;
      $display("FAIL timeout_req_cycles: got %0d want 15", req_cycles);
    end
    total++;
    if (err_cycles != 1 || err_at != last_req + 1) begin
      bad++;
      $display("FAIL timeout_err: got pulses=%0d at=%0d want 1 at %0d", err_cycles, err_at, last_req + 1);
    end
    total++;
    if (in_ready !== 1'b1 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL timeout_after: got rdy=%b writes=%0d want 1 0", in_ready, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_r0();
    @(posedge clk); #1;
    drive_op(32'd9, $urandom, 5'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    total++;
    if (RegWrite !== 1'b0 || WriteData !== 32'd9 || WriteRegister !== 5'd0) begin
      bad++;
      $display("FAIL r0_write: got rw=%b wd=%0d wr=%0d want 0 9 0", RegWrite, WriteData, WriteRegister);
    end
    repeat (2) @(negedge clk);
    total++;
    if (obs_q.size() != 0) begin
      bad++;
      $display("FAIL r0_no_write: got writes=%0d want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_access();
    int req_cycles = 0;
    @(posedge clk); #1;
    drive_op(32'hC0, $urandom, 5'd7, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre: got req=%b want 1", mem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_async: got req=%b rdy=%b want 0 1", mem_req, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBADC0DE0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (k == 1) mem_ack = 1'b0;
    end
    total++;
    if (req_cycles != 0 || in_ready !== 1'b1 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL rstmid_after: got req_cycles=%0d rdy=%b writes=%0d want 0 1 0",
               req_cycles, in_ready, obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_load();
    test_store();
    test_timeout();
    test_r0();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
